// File: rtl/dpd_cordic_pkg.sv
// dpd_cordic_pkg: widths, arctangent table, gain constant and FSM encoding
// shared by the iterative rotation CORDIC.
package dpd_cordic_pkg;
    localparam int DW = 24;
    localparam int PW = 24;
    localparam int ZW = 25;
    localparam int AW = 22;
    localparam logic signed [DW-1:0] K_Q23 = 24'sd5094007;

    typedef enum logic [1:0] {IDLE, ROT, GAIN, DONE} state_e;

    // round(atan(2^-k) / 2pi * 2^24)
    localparam logic signed [ZW-1:0] ATAN [AW] = '{
        25'sd2097152, 25'sd1238021, 25'sd654136, 25'sd332050,
        25'sd166669,  25'sd83416,   25'sd41718,  25'sd20860,
        25'sd10430,   25'sd5215,    25'sd2608,   25'sd1304,
        25'sd652,     25'sd326,     25'sd163,    25'sd81,
        25'sd41,      25'sd20,      25'sd10,     25'sd5,
        25'sd3,       25'sd1
    };

    function automatic logic signed [ZW-1:0] atan_lut(input logic [4:0] k);
        return ATAN[k];
    endfunction
endpackage

// File: rtl/cordic_rotate_step.sv
// cordic_rotate_step: one combinational rotation-mode micro-rotation with a
// runtime shift amount; direction follows the sign of the residual angle.
module cordic_rotate_step
    import dpd_cordic_pkg::*;
#(
    parameter int XW = DW + 2
) (
    input  logic signed [XW-1:0] x_i,
    input  logic signed [XW-1:0] y_i,
    input  logic signed [ZW-1:0] z_i,
    input  logic        [4:0]    k_i,
    input  logic signed [ZW-1:0] atan_i,
    output logic signed [XW-1:0] x_o,
    output logic signed [XW-1:0] y_o,
    output logic signed [ZW-1:0] z_o
);
    logic signed [XW-1:0] xs, ys;
    logic neg;

    always_comb begin
        neg = z_i[ZW-1];
        xs  = x_i >>> k_i;
        ys  = y_i >>> k_i;
        x_o = neg ? x_i + ys : x_i - ys;
        y_o = neg ? y_i - xs : y_i + xs;
        z_o = neg ? z_i + atan_i : z_i - atan_i;
    end
endmodule

// File: rtl/cordic_rotate_iter.sv
// cordic_rotate_iter: iterative rotation CORDIC, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a gain-compensation stage (unity gain).
module cordic_rotate_iter
    import dpd_cordic_pkg::*;
#(
    parameter int NUM_ITER = 20,
    parameter int GUARD    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] i_in,
    input  logic signed [DW-1:0] q_in,
    input  logic        [PW-1:0] phase_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] i_out,
    output logic signed [DW-1:0] q_out
);
    localparam int XW = DW + GUARD;
    localparam logic [4:0] K_LAST = 5'(NUM_ITER - 1);
`ifdef CORDIC_GAIN_COMP_EN
    localparam state_e ROT_EXIT = GAIN;
`else
    localparam state_e ROT_EXIT = DONE;
`endif

    state_e state_q, state_d;
    logic [4:0] k_q, k_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d, x_n, y_n, x_ld, y_ld, iw, qw;
    logic signed [ZW-1:0] z_q, z_d, z_n, z_ld;
    logic signed [DW-1:0] i_q, i_d, q_q, q_d;
    logic [1:0] quad;
    logic load, last;

    function automatic logic signed [DW-1:0] sat_x(input logic signed [XW-1:0] v);
        return (&v[XW-1:DW-1] | ~|v[XW-1:DW-1]) ? v[DW-1:0] : {v[XW-1], {(DW-1){~v[XW-1]}}};
    endfunction

    cordic_rotate_step #(.XW(XW)) u_step (
        .x_i(x_q), .y_i(y_q), .z_i(z_q), .k_i(k_q), .atan_i(atan_lut(k_q)),
        .x_o(x_n), .y_o(y_n), .z_o(z_n)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb
        state_d = state_q == IDLE ? (in_valid ? ROT : IDLE) :
                  state_q == ROT  ? (last ? ROT_EXIT : ROT) :
                  state_q == GAIN ? DONE :
                  (out_ready ? IDLE : DONE);

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
    end

    // Quadrant pre-rotation leaves a residual angle in [0, 90 deg).
    always_comb begin
        quad = phase_in[PW-1 -: 2];
        iw   = XW'(i_in);
        qw   = XW'(q_in);
        x_ld = quad == 2'd0 ? iw : quad == 2'd1 ? -qw : quad == 2'd2 ? -iw : qw;
        y_ld = quad == 2'd0 ? qw : quad == 2'd1 ? iw  : quad == 2'd2 ? -qw : -iw;
        z_ld = {3'b000, phase_in[PW-3:0]};
        load = state_q == IDLE && in_valid;
        last = k_q == K_LAST;
        x_d  = load ? x_ld : state_q == ROT ? x_n : x_q;
        y_d  = load ? y_ld : state_q == ROT ? y_n : y_q;
        z_d  = load ? z_ld : state_q == ROT ? z_n : z_q;
        k_d  = (state_q == ROT && !last) ? k_q + 5'd1 : '0;
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int MW = XW + DW;
    logic signed [MW-1:0] px, py;
    logic signed [XW-1:0] gx, gy;

    always_comb begin
        px  = MW'(x_q) * MW'(K_Q23);
        py  = MW'(y_q) * MW'(K_Q23);
        gx  = XW'((px + MW'(1 <<< 22)) >>> 23);
        gy  = XW'((py + MW'(1 <<< 22)) >>> 23);
        i_d = state_q == GAIN ? sat_x(gx) : i_q;
        q_d = state_q == GAIN ? sat_x(gy) : q_q;
    end
`else
    always_comb begin
        i_d = (state_q == ROT && last) ? sat_x(x_n) : i_q;
        q_d = (state_q == ROT && last) ? sat_x(y_n) : q_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            k_q <= '0;
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            i_q <= '0;
            q_q <= '0;
        end else begin
            k_q <= k_d;
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
            i_q <= i_d;
            q_q <= q_d;
        end

    assign i_out = i_q;
    assign q_out = q_q;
endmodule

// File: tb/tb_cordic_rotate_iter.sv
// tb_cordic_rotate_iter: scoreboard bench; the driver queues double-precision
// expectations on acceptance, the monitor checks each output handshake.
module tb_cordic_rotate_iter;
    localparam int N = 20;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int  LAT = N + 2;
    localparam real G   = 1.0;
`else
    localparam int  LAT = N + 1;
    localparam real G   = 1.6467602581;
`endif

    typedef struct { int i; int q; int tol; } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid;
    logic signed [23:0] i_in = '0, q_in = '0, i_out, q_out;
    logic [23:0] phase_in = '0;
    exp_t sb[$];
    int n_cmp = 0, n_err = 0, cyc = 0;

    cordic_rotate_iter #(.NUM_ITER(N), .GUARD(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .i_in(i_in), .q_in(q_in), .phase_in(phase_in), .out_valid(out_valid),
        .out_ready(out_ready), .i_out(i_out), .q_out(q_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        n_cmp++;
        if (act > exp + tol || act < exp - tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    function automatic int satr(input real v);
        if (v >= 8388607.0) return 8388607;
        if (v <= -8388608.0) return -8388608;
        return int'(v);
    endfunction

    function automatic exp_t model(input int i, input int q, input int ph);
        real th, m;
        exp_t e;
        th    = real'(ph) * 6.283185307179586 / 16777216.0;
        e.i   = satr(G * (real'(i) * $cos(th) - real'(q) * $sin(th)));
        e.q   = satr(G * (real'(i) * $sin(th) + real'(q) * $cos(th)));
        m     = G * $sqrt(real'(i) * real'(i) + real'(q) * real'(q));
        e.tol = 4 + int'(m / 262144.0);
        return e;
    endfunction

    task automatic send(input int i, input int q, input int ph);
        int t;
        i_in = 24'(i); q_in = 24'(q); phase_in = 24'(ph); in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: in_ready still %0d, expected 1", in_ready);
        end else begin
            sb.push_back(model(i, q, ph));
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        while (!out_valid && t < 300) begin @(posedge clk); #1; t++; end
        if (!out_valid) begin
            n_cmp++; n_err++;
            $display("FAIL out_timeout: out_valid still 0, expected 1");
        end
    endtask

    // Monitor: latency, accept spacing and result values at each handshake.
    int acc_cyc, prev_acc;
    bit have_acc = 0, prev_ov = 0;
    exp_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            have_acc = 0;
            prev_ov  = 0;
        end else begin
            if (out_valid && !prev_ov && have_acc) chk("latency", cyc - acc_cyc, LAT, 0);
            if (in_valid && in_ready) begin
                if (have_acc) begin
                    n_cmp++;
                    if (cyc - acc_cyc < N + 2) begin
                        n_err++;
                        $display("FAIL spacing: got %0d, expected >= %0d", cyc - acc_cyc, N + 2);
                    end
                end
                prev_acc = acc_cyc;
                acc_cyc  = cyc;
                have_acc = 1;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_output: got i=%0d q=%0d, expected none", i_out, q_out);
                end else begin
                    e = sb.pop_front();
                    chk("i_out", int'(i_out), e.i, e.tol);
                    chk("q_out", int'(q_out), e.q, e.tol);
                end
            end
            prev_ov = out_valid;
        end
    end

    int vi[8] = '{1000000, -2000000, 3000000, -500000, 123456, -3500000, 2500000, 0};
    int vq[8] = '{-2000000, 1500000, 250000, -3000000, 4000000, -100000, 2500000, -3900000};
    int vp[8] = '{'h0A1B2C, 'h3FFFFF, 'h400001, 'h7FFFFF, 'h8ABCDE, 'hBFFFFF, 'hC00000, 'hFFFFFF};

    initial begin
        int hi, hq, t;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1, 0);
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_i_out", int'(i_out), 0, 0);
        chk("rst_q_out", int'(q_out), 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(32'sh400000, 0, 'h000000); in_valid = 1'b0; wait_out();
        send(32'sh400000, 0, 'h400000); in_valid = 1'b0; wait_out();
        send(32'sh400000, 0, 'h800000); in_valid = 1'b0; wait_out();
        send(32'sh7FFFFF, 32'sh7FFFFF, 'h200000); in_valid = 1'b0; wait_out();
        send(-32'sh800000, 0, 'h800000); in_valid = 1'b0; wait_out();
        @(posedge clk); #1;

        // Backpressure with ignored input pulses while busy.
        out_ready = 1'b0;
        send(32'sh100000, -32'sh200000, 'h123456);
        in_valid = 1'b0;
        wait_out();
        hi = int'(i_out); hq = int'(q_out);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0]; i_in = 24'sh7FFFFF; q_in = 24'sh7FFFFF; phase_in = 24'h555555;
            @(posedge clk); #1;
            chk("bp_out_valid", int'(out_valid), 1, 0);
            chk("bp_in_ready", int'(in_ready), 0, 0);
            chk("bp_i_hold", int'(i_out), hi, 0);
            chk("bp_q_hold", int'(q_out), hq, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Back-to-back: in_valid stays high across all eight vectors.
        for (int v = 0; v < 8; v++) send(vi[v], vq[v], vp[v]);
        in_valid = 1'b0;
        wait_out();
        @(posedge clk); #1;

        // Abort in the middle of the rotation.
        send(32'sh200000, 32'sh100000, 'h300000);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0, 0);
        chk("abort_i_out", int'(i_out), 0, 0);
        chk("abort_q_out", int'(q_out), 0, 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", int'(in_ready), 1, 0);
        send(32'sh300000, 32'sh100000, 'hC00000);
        in_valid = 1'b0;

        t = 0;
        while (sb.size() != 0 && t < 500) begin @(posedge clk); #1; t++; end
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
